dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-request, open-page controller for a simple 32-bit SDRAM-style part.
// Accepts one request at a time, keeps the last activated row open, and issues
// PRE/ACT/RD/WR commands with programmable gaps. All outputs come from flops.
module dram_ctrl #(
    parameter int T_RP  = 5,
    parameter int T_RCD = 5,
    parameter int T_WR  = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid
);

    // Wait counters count down to zero, so the load value is (wait cycles - 1).
    // PRE_WAIT/ACT_WAIT last T-1 cycles; WR_WAIT lasts T_WR cycles.
    localparam logic [3:0] RP_LOAD  = (T_RP  > 1) ? 4'(T_RP  - 2) : 4'd0;
    localparam logic [3:0] RCD_LOAD = (T_RCD > 1) ? 4'(T_RCD - 2) : 4'd0;
    localparam logic [3:0] WR_LOAD  = (T_WR  > 0) ? 4'(T_WR  - 1) : 4'd0;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        PRE_WAIT,
        ACT,
        ACT_WAIT,
        COL,
        RD_WAIT,
        WR_WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_d;

    // Open-page bookkeeping
    logic        open_vld;
    logic [10:0] open_row;

    // Shared wait counter for PRE_WAIT / ACT_WAIT / WR_WAIT
    logic [3:0]  cnt;

    // Request captured on acceptance
    logic        lat_write;
    logic [10:0] lat_row;
    logic [9:0]  lat_col;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;

    // Request view used by the decoder: live inputs while accepting, latched copy afterwards
    logic        cur_write;
    logic [10:0] cur_row;
    logic [9:0]  cur_col;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;

    logic        accept;

    // Command pins for the next cycle, decoded from the state being entered
    logic        cs_n_p0;
    logic        ras_n_p0;
    logic        cas_n_p0;
    logic [3:0]  we_n_p0;
    logic [10:0] a_p0;
    logic [31:0] d_p0;

    // Select live request fields in IDLE so a row hit can issue its column command right away
    always_comb begin
        cur_write = lat_write;
        cur_row   = lat_row;
        cur_col   = lat_col;
        cur_wdata = lat_wdata;
        cur_wstrb = lat_wstrb;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_row   = req_addr[20:10];
            cur_col   = req_addr[9:0];
            cur_wdata = req_wdata;
            cur_wstrb = req_wstrb;
        end
    end

    // Next-state logic: page-hit/miss decision in IDLE, timed waits elsewhere
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (open_vld && (open_row == req_addr[20:10])) begin
                        state_d = COL;
                    end else if (open_vld) begin
                        state_d = PRE;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            PRE: begin
                if (T_RP > 1) begin
                    state_d = PRE_WAIT;
                end else begin
                    state_d = ACT;
                end
            end
            PRE_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                if (T_RCD > 1) begin
                    state_d = ACT_WAIT;
                end else begin
                    state_d = COL;
                end
            end
            ACT_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = COL;
                end
            end
            COL: begin
                if (cur_write) begin
                    state_d = WR_WAIT;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DRAM_valid) begin
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command decode: each command state is occupied for exactly one cycle, so the pins pulse once
    always_comb begin
        cs_n_p0  = 1'b1;
        ras_n_p0 = 1'b1;
        cas_n_p0 = 1'b1;
        we_n_p0  = 4'hF;
        a_p0     = 11'h000;
        d_p0     = 32'h0000_0000;
        case (state_d)
            PRE: begin
                cs_n_p0  = 1'b0;
                ras_n_p0 = 1'b0;
                we_n_p0  = 4'h0;
            end
            ACT: begin
                cs_n_p0  = 1'b0;
                ras_n_p0 = 1'b0;
                a_p0     = cur_row;
            end
            COL: begin
                cs_n_p0  = 1'b0;
                cas_n_p0 = 1'b0;
                a_p0     = {1'b0, cur_col};
                if (cur_write) begin
                    we_n_p0 = ~cur_wstrb;
                    d_p0    = cur_wdata;
                end
            end
            default: begin
            end
        endcase
    end

    // State register, wait counter and open-row tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            open_vld <= 1'b0;
            open_row <= 11'h000;
        end else begin
            state <= state_d;
            case (state)
                PRE: begin
                    cnt      <= RP_LOAD;
                    open_vld <= 1'b0;
                end
                ACT: begin
                    cnt      <= RCD_LOAD;
                    open_vld <= 1'b1;
                    open_row <= lat_row;
                end
                COL: begin
                    cnt <= WR_LOAD;
                end
                PRE_WAIT, ACT_WAIT, WR_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request capture; data-only, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_row   <= req_addr[20:10];
            lat_col   <= req_addr[9:0];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    // Registered DRAM command pins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            DRAM_CSn  <= 1'b1;
            DRAM_RASn <= 1'b1;
            DRAM_CASn <= 1'b1;
            DRAM_WEn  <= 4'hF;
            DRAM_A    <= 11'h000;
            DRAM_D    <= 32'h0000_0000;
        end else begin
            DRAM_CSn  <= cs_n_p0;
            DRAM_RASn <= ras_n_p0;
            DRAM_CASn <= cas_n_p0;
            DRAM_WEn  <= we_n_p0;
            DRAM_A    <= a_p0;
            DRAM_D    <= d_p0;
        end
    end

    // Handshake and response: ready only in IDLE, rsp_valid only in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
        end else begin
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == DONE);
            if ((state == RD_WAIT) && DRAM_valid) begin
                rsp_rdata <= DRAM_Q;
            end else if ((state == WR_WAIT) && (cnt == 4'd0)) begin
                rsp_rdata <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed and randomized bench for dram_ctrl. The bench plays the DRAM,
// keeps a word-level memory image and open-row state, and predicts every output per cycle.
module tb_dram_ctrl;

    localparam int T_RP  = 5;
    localparam int T_RCD = 5;
    localparam int T_WR  = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [20:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;

    always #5 clk = ~clk;

    dram_ctrl #(
        .T_RP (T_RP),
        .T_RCD(T_RCD),
        .T_WR (T_WR)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .DRAM_CSn  (DRAM_CSn),
        .DRAM_RASn (DRAM_RASn),
        .DRAM_CASn (DRAM_CASn),
        .DRAM_WEn  (DRAM_WEn),
        .DRAM_A    (DRAM_A),
        .DRAM_D    (DRAM_D),
        .DRAM_Q    (DRAM_Q),
        .DRAM_valid(DRAM_valid)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: which row the part has open, memory contents, last response word
    logic        mdl_open;
    logic [10:0] mdl_row;
    logic [31:0] mdl_mem [int];
    logic [31:0] last_rdata;

    logic [10:0] rows [4] = '{11'h000, 11'h001, 11'h003, 11'h7FF};

    function automatic logic [31:0] mem_rd(input logic [20:0] addr);
        if (mdl_mem.exists(int'(addr))) return mdl_mem[int'(addr)];
        return {addr[15:0], ~addr[15:0]};
    endfunction

    function automatic logic [51:0] mk(input logic cs, input logic ras, input logic cas,
                                       input logic [3:0] we, input logic [10:0] a,
                                       input logic [31:0] d, input logic rv, input logic rr);
        return {cs, ras, cas, we, a, d, rv, rr};
    endfunction

    function automatic logic [51:0] bus_now();
        return {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D, rsp_valid, req_ready};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn       = 1'b0;
        req_valid  = 1'b0;
        DRAM_valid = 1'b0;
        #1;
        chk("reset_pins", 64'(bus_now()),
            64'(mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, 1'b0, 1'b1)));
        chk("reset_rdata", 64'(rsp_rdata), 64'(32'h0));
        @(negedge clk);
        rstn       = 1'b1;
        mdl_open   = 1'b0;
        mdl_row    = 11'h000;
        last_rdata = 32'h0;
    endtask

    // Pulse DRAM_valid with junk data while the controller is idle
    task automatic idle_q_pulse(input string tag);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            DRAM_valid = 1'b1;
            DRAM_Q     = $urandom;
            @(negedge clk);
            DRAM_valid = 1'b0;
            chk($sformatf("%s_%0d", tag, k), 64'({rsp_valid, req_ready, rsp_rdata}),
                64'({1'b0, 1'b1, last_rdata}));
        end
    endtask

    // One complete transaction with a per-cycle prediction of every output
    task automatic txn(input string tag, input logic wr, input logic [20:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input int qd);
        int          n;
        int          pre_c;
        int          act_c;
        int          col_c;
        int          d;
        logic [10:0] row;
        logic [9:0]  col;
        logic [51:0] want;
        logic [51:0] msk;
        logic [51:0] msk_no_d;
        logic [51:0] msk_no_ad;
        logic [31:0] rd_word;
        logic [31:0] merged;

        row       = addr[20:10];
        col       = addr[9:0];
        msk_no_d  = mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h7FF, 32'h0, 1'b1, 1'b1);
        msk_no_ad = mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, 1'b1, 1'b1);

        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1'b1));
        if (req_ready !== 1'b1) begin
            apply_reset();
            return;
        end

        pre_c = 0;
        act_c = 0;
        if (mdl_open && mdl_row == row) begin
            col_c = 1;
        end else if (mdl_open) begin
            pre_c = 1;
            act_c = 1 + T_RP;
            col_c = act_c + T_RCD;
        end else begin
            act_c = 1;
            col_c = 1 + T_RCD;
        end
        d       = wr ? (col_c + T_WR + 1) : (col_c + qd + 1);
        rd_word = mem_rd(addr);

        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_wstrb  = ws;
        DRAM_valid = 1'b0;

        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            want = mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, (k == d), (k == d + 1));
            msk  = '1;
            if (k == pre_c) begin
                want = mk(1'b0, 1'b0, 1'b1, 4'h0, 11'h000, 32'h0, 1'b0, 1'b0);
                msk  = msk_no_ad;
            end else if (k == act_c) begin
                want = mk(1'b0, 1'b0, 1'b1, 4'hF, row, 32'h0, 1'b0, 1'b0);
                msk  = msk_no_d;
            end else if (k == col_c) begin
                if (wr) begin
                    want = mk(1'b0, 1'b1, 1'b0, ~ws, {1'b0, col}, wd, 1'b0, 1'b0);
                end else begin
                    want = mk(1'b0, 1'b1, 1'b0, 4'hF, {1'b0, col}, 32'h0, 1'b0, 1'b0);
                    msk  = msk_no_d;
                end
            end
            chk($sformatf("%s_c%0d", tag, k), 64'(bus_now() & msk), 64'(want & msk));
            if (k == d) begin
                chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(wr ? 32'h0 : rd_word));
            end

            // Keep a different request offered while busy; it must not be taken
            req_valid = (k <= d);
            req_write = 1'($urandom);
            req_addr  = 21'($urandom);
            req_wdata = $urandom;
            req_wstrb = 4'($urandom);

            // DRAM side: real data once for reads, junk strobes where they must be ignored
            DRAM_Q     = $urandom;
            DRAM_valid = 1'b0;
            if (!wr && k == col_c + qd) begin
                DRAM_valid = 1'b1;
                DRAM_Q     = rd_word;
            end else if ((wr && k <= d) || (!wr && k < col_c)) begin
                DRAM_valid = ($urandom_range(0, 3) == 0);
            end
        end

        req_valid  = 1'b0;
        DRAM_valid = 1'b0;
        mdl_open   = 1'b1;
        mdl_row    = row;
        if (wr) begin
            merged = mem_rd(addr);
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
            end
            mdl_mem[int'(addr)] = merged;
            last_rdata = 32'h0;
        end else begin
            last_rdata = rd_word;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [20:0] a;

        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 21'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        DRAM_Q     = 32'h0;
        DRAM_valid = 1'b0;
        mdl_open   = 1'b0;
        mdl_row    = 11'h000;
        last_rdata = 32'h0;

        apply_reset();
        idle_q_pulse("idle_q_after_reset");

        txn("cold_rd",   1'b0, 21'h00C05, 32'h0,        4'h0,    3);
        txn("hit_wr",    1'b1, 21'h00C06, 32'hDEADBEEF, 4'b0101, 1);
        txn("miss_rd",   1'b0, 21'h01400, 32'h0,        4'h0,    2);
        txn("wr_nostrb", 1'b1, 21'h01401, 32'h12345678, 4'h0,    1);
        txn("rd_back",   1'b0, 21'h00C06, 32'h0,        4'h0,    1);
        txn("max_wr",    1'b1, 21'h1FFFFF, 32'hA5A5_5A5A, 4'hF,  1);
        txn("max_rd",    1'b0, 21'h1FFFFF, 32'h0,        4'h0,    5);

        // Reset while waiting out tRCD: transaction is dropped, next access re-activates
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 21'h00C07;
        @(negedge clk);
        chk("midrst_act", 64'(bus_now() & mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h7FF, 32'h0, 1'b1, 1'b1)),
            64'(mk(1'b0, 1'b0, 1'b1, 4'hF, 11'h003, 32'h0, 1'b0, 1'b0)));
        req_addr = 21'h1A5A5;
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_nop", 64'(bus_now()),
            64'(mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, 1'b0, 1'b1)));
        req_valid = 1'b0;
        @(negedge clk);
        rstn       = 1'b1;
        mdl_open   = 1'b0;
        last_rdata = 32'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_quiet_%0d", k), 64'({bus_now(), rsp_rdata}),
                64'({mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, 1'b0, 1'b1), 32'h0}));
        end
        txn("post_rst_rd", 1'b0, 21'h00C07, 32'h0, 4'h0, 2);

        for (int i = 0; i < 40; i++) begin
            a = {rows[$urandom_range(0, 3)], 10'($urandom)};
            txn($sformatf("rnd%0d", i), 1'($urandom), a, $urandom, 4'($urandom),
                int'($urandom_range(1, 6)));
        end

        idle_q_pulse("idle_q_after_traffic");

        @(negedge clk);
        chk("final_idle", 64'(bus_now()),
            64'(mk(1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0, 1'b0, 1'b1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
